// File: rtl/lc3_pkg.sv
// Shared LC-3 decode definitions: opcode enum, control field encodings and the
// execute-control bundle layout.
package lc3_pkg;

   typedef enum logic [3:0] {
      OpBr   = 4'h0,
      OpAdd  = 4'h1,
      OpLd   = 4'h2,
      OpSt   = 4'h3,
      OpRsv4 = 4'h4,
      OpAnd  = 4'h5,
      OpLdr  = 4'h6,
      OpStr  = 4'h7,
      OpRsv8 = 4'h8,
      OpNot  = 4'h9,
      OpLdi  = 4'hA,
      OpSti  = 4'hB,
      OpJmp  = 4'hC,
      OpRsvD = 4'hD,
      OpLea  = 4'hE,
      OpRsvF = 4'hF
   } op_t;

   localparam logic [1:0] AluAdd = 2'b00;
   localparam logic [1:0] AluAnd = 2'b01;
   localparam logic [1:0] AluNot = 2'b10;

   localparam logic [1:0] PcSel1None = 2'b00;
   localparam logic [1:0] PcSel1Off6 = 2'b01;
   localparam logic [1:0] PcSel1Off9 = 2'b10;

   localparam logic PcSel2Base = 1'b0;
   localparam logic PcSel2Npc  = 1'b1;

   localparam logic [1:0] WbAlu = 2'b00;
   localparam logic [1:0] WbMem = 2'b01;
   localparam logic [1:0] WbPc  = 2'b10;

   // Field order matches the E_control bus, MSB first.
   typedef struct packed {
      logic [1:0] alu;
      logic [1:0] pcsel1;
      logic       pcsel2;
      logic       op2sel;
   } e_ctrl_t;

endpackage

// File: rtl/lc3_decode_ctrl.sv
// Combinational opcode-to-control mapping for the LC-3 decode stage.
module lc3_decode_ctrl
   import lc3_pkg::*;
(
   input  logic [3:0] opcode_i,
   input  logic       imm_flag_i,
   output logic [5:0] e_control_o,
   output logic [1:0] w_control_o,
   output logic       mem_control_o,
   output logic       illegal_o
);

   op_t     op;
   e_ctrl_t e_ctrl;

   assign op = op_t'(opcode_i);

   always_comb begin
      e_ctrl        = '0;
      w_control_o   = WbAlu;
      mem_control_o = 1'b0;
      illegal_o     = 1'b0;
      unique case (op)
         OpAdd: begin
            e_ctrl.alu    = AluAdd;
            e_ctrl.op2sel = ~imm_flag_i;
         end
         OpAnd: begin
            e_ctrl.alu    = AluAnd;
            e_ctrl.op2sel = ~imm_flag_i;
         end
         OpNot: begin
            e_ctrl.alu = AluNot;
         end
         OpLd: begin
            e_ctrl.pcsel1 = PcSel1Off9;
            e_ctrl.pcsel2 = PcSel2Npc;
            w_control_o   = WbMem;
         end
         OpLdi: begin
            e_ctrl.pcsel1 = PcSel1Off9;
            e_ctrl.pcsel2 = PcSel2Npc;
            w_control_o   = WbMem;
            mem_control_o = 1'b1;
         end
         OpLea: begin
            e_ctrl.pcsel1 = PcSel1Off9;
            e_ctrl.pcsel2 = PcSel2Npc;
            w_control_o   = WbPc;
         end
         OpSt, OpBr: begin
            e_ctrl.pcsel1 = PcSel1Off9;
            e_ctrl.pcsel2 = PcSel2Npc;
         end
         OpSti: begin
            e_ctrl.pcsel1 = PcSel1Off9;
            e_ctrl.pcsel2 = PcSel2Npc;
            mem_control_o = 1'b1;
         end
         OpLdr: begin
            e_ctrl.pcsel1 = PcSel1Off6;
            e_ctrl.pcsel2 = PcSel2Base;
            w_control_o   = WbMem;
         end
         OpStr: begin
            e_ctrl.pcsel1 = PcSel1Off6;
            e_ctrl.pcsel2 = PcSel2Base;
         end
         OpJmp: begin
            e_ctrl.pcsel1 = PcSel1None;
            e_ctrl.pcsel2 = PcSel2Base;
         end
         OpRsv4, OpRsv8, OpRsvD, OpRsvF: begin
            illegal_o = 1'b1;
         end
      endcase
   end

   assign e_control_o = e_ctrl;

endmodule

// File: rtl/lc3_decode.sv
// LC-3 decode stage: registers the fetched instruction, its NPC and the decoded
// execute/writeback/memory controls with one cycle of latency.
module lc3_decode
   import lc3_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        enable_decode,
   input  logic [15:0] dout,
   input  logic [15:0] npc_in,
   output logic [15:0] IR,
   output logic [15:0] npc_out,
   output logic [5:0]  E_control,
   output logic [1:0]  W_control,
   output logic        Mem_control,
   output logic        decode_valid,
   output logic        illegal
);

   logic [5:0]  e_control_d;
   logic [1:0]  w_control_d;
   logic        mem_control_d;
   logic        illegal_d;

   logic [15:0] ir_q;
   logic [15:0] npc_q;
   logic [5:0]  e_control_q;
   logic [1:0]  w_control_q;
   logic        mem_control_q;
   logic        valid_q;
   logic        illegal_q;

   lc3_decode_ctrl u_ctrl (
      .opcode_i      (dout[15:12]),
      .imm_flag_i    (dout[5]),
      .e_control_o   (e_control_d),
      .w_control_o   (w_control_d),
      .mem_control_o (mem_control_d),
      .illegal_o     (illegal_d)
   );

   // Payload registers only advance on an accepted instruction; the valid
   // flag tracks enable_decode every cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         ir_q          <= '0;
         npc_q         <= '0;
         e_control_q   <= '0;
         w_control_q   <= '0;
         mem_control_q <= 1'b0;
         valid_q       <= 1'b0;
         illegal_q     <= 1'b0;
      end else begin
         valid_q <= enable_decode;
         if (enable_decode) begin
            ir_q          <= dout;
            npc_q         <= npc_in;
            e_control_q   <= e_control_d;
            w_control_q   <= w_control_d;
            mem_control_q <= mem_control_d;
            illegal_q     <= illegal_d;
         end
      end
   end

   assign IR           = ir_q;
   assign npc_out      = npc_q;
   assign E_control    = e_control_q;
   assign W_control    = w_control_q;
   assign Mem_control  = mem_control_q;
   assign decode_valid = valid_q;
   assign illegal      = illegal_q;

endmodule

// File: tb/tb_lc3_decode.sv
// Self-checking bench for lc3_decode: directed cases plus randomized traffic
// compared against a mnemonic-level reference model.
module tb_lc3_decode;

   logic        clock;
   logic        reset;
   logic        enable_decode;
   logic [15:0] dout;
   logic [15:0] npc_in;
   logic [15:0] IR;
   logic [15:0] npc_out;
   logic [5:0]  E_control;
   logic [1:0]  W_control;
   logic        Mem_control;
   logic        decode_valid;
   logic        illegal;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference state
   logic [15:0] m_ir, m_npc;
   logic [5:0]  m_e;
   logic [1:0]  m_w;
   logic        m_mem, m_valid, m_ill;

   string mn [16];

   lc3_decode dut (
      .clock        (clock),
      .reset        (reset),
      .enable_decode(enable_decode),
      .dout         (dout),
      .npc_in       (npc_in),
      .IR           (IR),
      .npc_out      (npc_out),
      .E_control    (E_control),
      .W_control    (W_control),
      .Mem_control  (Mem_control),
      .decode_valid (decode_valid),
      .illegal      (illegal)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit is_one_of(input string m, input string a, input string b,
                                    input string c, input string d, input string e,
                                    input string f);
      return (m == a) || (m == b) || (m == c) || (m == d) || (m == e) || (m == f);
   endfunction

   // Expected controls for one instruction word, derived from its mnemonic.
   task automatic ref_decode(input logic [15:0] instr, output logic [5:0] e,
                             output logic [1:0] w, output logic mem, output logic ill);
      string m;
      logic [1:0] alu, p1;
      logic       p2, o2;
      m   = mn[instr[15:12]];
      alu = (m == "AND") ? 2'd1 : (m == "NOT") ? 2'd2 : 2'd0;
      o2  = ((m == "ADD") || (m == "AND")) && !instr[5];
      if (is_one_of(m, "LD", "LDI", "LEA", "ST", "STI", "BR")) begin
         p1 = 2'b10; p2 = 1'b1;
      end else if (is_one_of(m, "LDR", "STR", "", "", "", "")) begin
         p1 = 2'b01; p2 = 1'b0;
      end else begin
         p1 = 2'b00; p2 = 1'b0;
      end
      e   = {alu, p1, p2, o2};
      w   = is_one_of(m, "LD", "LDR", "LDI", "", "", "") ? 2'b01 : (m == "LEA") ? 2'b10 : 2'b00;
      mem = (m == "LDI") || (m == "STI");
      ill = (m == "ILL");
      if (ill) begin
         e = '0; w = '0; mem = 1'b0;
      end
   endtask

   // Apply one cycle of inputs, advance the model, and compare every output.
   task automatic step(input logic rst, input logic en, input logic [15:0] d,
                       input logic [15:0] npc);
      logic [5:0] e;
      logic [1:0] w;
      logic       mem, ill;
      reset = rst; enable_decode = en; dout = d; npc_in = npc;
      @(posedge clock);
      if (rst) begin
         m_ir = '0; m_npc = '0; m_e = '0; m_w = '0; m_mem = 0; m_valid = 0; m_ill = 0;
      end else begin
         m_valid = en;
         if (en) begin
            ref_decode(d, e, w, mem, ill);
            m_ir = d; m_npc = npc; m_e = e; m_w = w; m_mem = mem; m_ill = ill;
         end
      end
      #1;
      check("IR", IR, m_ir);
      check("npc_out", npc_out, m_npc);
      check("E_control", {10'd0, E_control}, {10'd0, m_e});
      check("W_control", {14'd0, W_control}, {14'd0, m_w});
      check("Mem_control", {15'd0, Mem_control}, {15'd0, m_mem});
      check("decode_valid", {15'd0, decode_valid}, {15'd0, m_valid});
      check("illegal", {15'd0, illegal}, {15'd0, m_ill});
   endtask

   initial begin
      mn = '{"BR", "ADD", "LD", "ST", "ILL", "AND", "LDR", "STR",
             "ILL", "NOT", "LDI", "STI", "JMP", "ILL", "LEA", "ILL"};
      reset = 1'b1; enable_decode = 1'b0; dout = '0; npc_in = '0;

      // Reset state
      step(1, 0, 16'h0000, 16'h0000);
      step(1, 1, 16'h12A3, 16'h3001);
      check("rst_IR", IR, 16'h0000);
      check("rst_valid", {15'd0, decode_valid}, 16'h0000);

      // First edge after reset with enable low
      step(0, 0, 16'h12A3, 16'h3001);
      check("post_rst_valid", {15'd0, decode_valid}, 16'h0000);

      // ADD imm
      step(0, 1, 16'h12A3, 16'h3001);
      check("add_imm_IR", IR, 16'h12A3);
      check("add_imm_npc", npc_out, 16'h3001);
      check("add_imm_E", {10'd0, E_control}, 16'h0000);
      check("add_imm_valid", {15'd0, decode_valid}, 16'h0001);

      // Hold while disabled
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 16'hFFFF, 16'hBEEF);
         check("hold_IR", IR, 16'h12A3);
         check("hold_valid", {15'd0, decode_valid}, 16'h0000);
      end

      step(0, 1, 16'h1042, 16'h3002);
      check("add_reg_E", {10'd0, E_control}, 16'h0001);
      step(0, 1, 16'h9000, 16'h3003);
      check("not_E", {10'd0, E_control}, 16'h0020);
      check("not_W", {14'd0, W_control}, 16'h0000);
      step(0, 1, 16'h2605, 16'h3004);
      check("ld_E", {10'd0, E_control}, 16'h000A);
      check("ld_W", {14'd0, W_control}, 16'h0001);
      check("ld_Mem", {15'd0, Mem_control}, 16'h0000);
      step(0, 1, 16'hA605, 16'h3005);
      check("ldi_E", {10'd0, E_control}, 16'h000A);
      check("ldi_W", {14'd0, W_control}, 16'h0001);
      check("ldi_Mem", {15'd0, Mem_control}, 16'h0001);
      step(0, 1, 16'h62BF, 16'h3006);
      check("ldr_E", {10'd0, E_control}, 16'h0004);
      check("ldr_W", {14'd0, W_control}, 16'h0001);
      step(0, 1, 16'hC0C0, 16'h3007);
      check("jmp_E", {10'd0, E_control}, 16'h0000);
      step(0, 1, 16'hE1FF, 16'h3008);
      check("lea_W", {14'd0, W_control}, 16'h0002);

      // Illegal opcode, then cleared by the next legal instruction
      step(0, 1, 16'hF025, 16'h3009);
      check("ill_flag", {15'd0, illegal}, 16'h0001);
      check("ill_E", {10'd0, E_control}, 16'h0000);
      check("ill_IR", IR, 16'hF025);
      step(0, 1, 16'h5020, 16'h300A);
      check("ill_clear", {15'd0, illegal}, 16'h0000);
      step(0, 1, 16'h8000, 16'h300B);
      check("ill8_flag", {15'd0, illegal}, 16'h0001);

      // Reset wins over a simultaneous accept
      step(1, 1, 16'h12A3, 16'h3001);
      check("rst_prio_IR", IR, 16'h0000);
      check("rst_prio_ill", {15'd0, illegal}, 16'h0000);
      check("rst_prio_npc", npc_out, 16'h0000);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
              16'($urandom), 16'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lc3_decode.md
LC3_DECODE -- requirements
Module: lc3_decode

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: ports clock and reset.
REQ-002 SHALL have port: clock  in  1  stage clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous active-high reset.
REQ-004 SHALL have port: enable_decode  in  1  fetch-stage qualifier; 1 = dout/npc_in valid this cycle.
REQ-005 SHALL have port: dout  in  16  instruction word from instruction memory.
REQ-006 SHALL have port: npc_in  in  16  PC+1 of the instruction on dout.
REQ-007 SHALL have port: IR  out  16  registered instruction.
REQ-008 SHALL have port: npc_out  out  16  registered npc_in.
REQ-009 SHALL have port: E_control  out  6  {alu_control[5:4], pcselect1[3:2], pcselect2[1], op2select[0]}.
REQ-010 SHALL have port: W_control  out  2  writeback source.
REQ-011 SHALL have port: Mem_control  out  1  1 = indirect memory access.
REQ-012 SHALL have port: decode_valid  out  1  registered enable_decode; qualifies all outputs to execute.
REQ-013 SHALL have port: illegal  out  1  registered flag for unsupported opcode.

Function
REQ-014 SHALL sample dout, npc_in and the decoded controls into output registers on a rising edge where enable_decode=1 and reset=0; latency is one cycle.
REQ-015 SHALL hold IR, npc_out, E_control, W_control, Mem_control and illegal unchanged on any edge where enable_decode=0.
REQ-016 SHALL load decode_valid with enable_decode on every non-reset edge.
REQ-017 SHALL decode from dout[15:12]: ADD 0001, AND 0101, NOT 1001, LD 0010, LDR 0110, LDI 1010, LEA 1110, ST 0011, STR 0111, STI 1011, BR 0000, JMP 1100.
REQ-018 SHALL set alu_control to ADD=00, AND=01, NOT=10, and 00 for all other opcodes.
REQ-019 SHALL set op2select to 1 for ADD/AND with dout[5]=0 (VSR2) and 0 for every other case (imm5 or unused).
REQ-020 SHALL set pcselect1 to 10 (pcoffset9) with pcselect2=1 (npc) for LD, LDI, LEA, ST, STI and BR.
REQ-021 SHALL set pcselect1 to 01 (pcoffset6) with pcselect2=0 (base register) for LDR and STR.
REQ-022 SHALL set pcselect1 to 00 with pcselect2=0 for JMP and for ADD/AND/NOT.
REQ-023 SHALL set W_control to 00 (ALU) for ADD/AND/NOT, 01 (memory) for LD/LDR/LDI, 10 (PC) for LEA, and 00 for all other opcodes.
REQ-024 SHALL set Mem_control to 1 for LDI and STI only.
REQ-025 SHALL, for opcodes 0100, 1000, 1101 and 1111, drive all-zero E_control/W_control/Mem_control, load IR/npc_out normally, and set illegal=1.
REQ-026 SHALL clear illegal when the next legal instruction is accepted.
REQ-027 SHALL pass npc_in through unmodified, with no arithmetic on it.

Reset
REQ-028 SHALL, on an edge with reset=1, clear IR, npc_out, E_control, W_control, Mem_control, decode_valid and illegal to 0.
REQ-029 SHALL give reset priority over a simultaneous enable_decode=1, so the instruction is dropped.
REQ-030 SHALL produce decode_valid=0 on the first edge after reset deasserts unless enable_decode=1 on that edge.

Structure
REQ-031 SHALL take the opcode enum op_t and the alu_control, pcselect and W_control encoding constants from a shared package, lc3_pkg.
REQ-032 SHALL place the purely combinational opcode-to-control mapping in one sub-module, lc3_decode_ctrl.
REQ-033 SHALL keep all registers in lc3_decode.

Verification
REQ-034 SHALL cover: dout=0x12A3 (ADD R1,R2,#3), npc_in=0x3001, enable=1 -> next cycle IR=0x12A3, npc_out=0x3001, E=000000, W=00, Mem=0, decode_valid=1.
REQ-035 SHALL cover: dout=0x1042 (ADD reg) -> E=000001; then dout=0x9000 (NOT) -> E=100000, W=00.
REQ-036 SHALL cover: dout=0x2605 (LD) -> E=001010, W=01, Mem=0; then dout=0xA605 (LDI) -> E=001010, W=01, Mem=1.
REQ-037 SHALL cover: dout=0x62BF (LDR) -> E=000100, W=01; then dout=0xC0C0 (JMP) -> E=000000.
REQ-038 SHALL cover: after an accepted 0x12A3, drive enable=0 with dout=0xFFFF for 3 cycles -> IR stays 0x12A3 and decode_valid=0.
REQ-039 SHALL cover: dout=0xF025 with enable=1 -> illegal=1 and controls 0; then reset=1 with enable=1 and dout=0x12A3 -> all outputs 0 on the next cycle.
